// File: rtl/seg_display_ctrl.sv
// Bus-mapped 4-digit display controller with hex passthrough or 14-step
// double-dabble binary-to-BCD conversion, plus a free-running scan-tick divider.
module seg_display_ctrl #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        FEPU_BEPU_w,
  input  logic        addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [15:0] data_out,
  output logic        scan_ena,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [15:0] DEC_MAX = 16'd9999;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_next;
  logic [CW-1:0] div_cnt;
  logic [15:0] value_reg;
  logic        dec_mode;
  logic [13:0] src;
  logic [15:0] bcd;
  logic [3:0]  bit_cnt;
  logic [15:0] bcd_step;
  logic        wr_value, wr_ctrl, rd, load_conv, abort_conv;
  logic        unused_bits;

  assign unused_bits = &{1'b0, wdata[31:16]};

  // One double-dabble iteration: adjust every nibble >= 5, then shift in a bit.
  function automatic logic [15:0] dabble_step(input logic [15:0] b, input logic in_bit);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      adj[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return {adj[14:0], in_bit};
  endfunction

  assign bcd_step = dabble_step(bcd, src[13]);
  assign busy     = (state == CONV);
  assign scan_ena = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    wr_value   = ena && FEPU_BEPU_w && !addr;
    wr_ctrl    = ena && FEPU_BEPU_w && addr;
    rd         = ena && !FEPU_BEPU_w;
    load_conv  = wr_value && dec_mode;
    abort_conv = wr_ctrl && !wdata[0] && (state == CONV);
    state_next = state;
    case (state)
      IDLE: begin
        if (load_conv) state_next = CONV;
      end
      CONV: begin
        if (load_conv)           state_next = CONV;
        else if (abort_conv)     state_next = IDLE;
        else if (bit_cnt == 4'd13) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Register file, read port and conversion datapath. A new VALUE write
  // always wins over an in-flight step, so restarts need no extra state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata     <= '0;
      value_reg <= '0;
      dec_mode  <= 1'b0;
      data_out  <= '0;
      ovf       <= 1'b0;
      src       <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
    end else begin
      if (rd) begin
        rdata <= addr ? {31'h0, dec_mode} : {16'h0, value_reg};
      end
      if (wr_value) begin
        value_reg <= wdata[15:0];
      end
      if (wr_ctrl) begin
        dec_mode <= wdata[0];
      end

      if (wr_value && !dec_mode) begin
        data_out <= wdata[15:0];
        ovf      <= 1'b0;
      end else if (load_conv) begin
        if (wdata[15:0] > DEC_MAX) begin
          src <= DEC_MAX[13:0];
          ovf <= 1'b1;
        end else begin
          src <= wdata[13:0];
          ovf <= 1'b0;
        end
        bcd     <= '0;
        bit_cnt <= '0;
      end else if (abort_conv) begin
        data_out <= value_reg;
        ovf      <= 1'b0;
      end else if (state == CONV) begin
        bcd     <= bcd_step;
        src     <= {src[12:0], 1'b0};
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd13) begin
          data_out <= bcd_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: table-driven bus vectors plus
// hand-written decimal conversion, restart, abort and reset sequences.
module tb_seg_display_ctrl;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        we;
  logic        addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] data_out;
  logic        scan_ena;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_dout;
  logic        m_ovf;
  logic [31:0] m_rdata;

  typedef struct {
    string       name;
    logic [15:0] dout;
    logic        busy;
    logic        ovf;
    logic [31:0] rdata;
    bit          chk_rdata;
  } exp_t;

  typedef struct {
    logic        e;
    logic        w;
    logic        a;
    logic [31:0] d;
    logic [15:0] dout;
    logic [31:0] rdata;
  } vec_t;

  exp_t sb[$];

  seg_display_ctrl #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .FEPU_BEPU_w(we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .data_out   (data_out),
    .scan_ena   (scan_ena),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference BCD built by division, independent of the shift-add method.
  function automatic logic [15:0] to_bcd(input logic [15:0] v);
    int s;
    s = (v > 16'd9999) ? 9999 : int'(v);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic applyStimulus(input logic e, input logic w, input logic a, input logic [31:0] d);
    @(negedge clk);
    ena = e; we = w; addr = a; wdata = d;
    @(posedge clk);
  endtask

  task automatic checkOutput();
    exp_t x;
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({x.name, "_data_out"}, {16'h0, data_out}, {16'h0, x.dout});
      chk({x.name, "_busy"}, {31'h0, busy}, {31'h0, x.busy});
      chk({x.name, "_ovf"}, {31'h0, ovf}, {31'h0, x.ovf});
      if (x.chk_rdata) chk({x.name, "_rdata"}, rdata, x.rdata);
    end
  endtask

  task automatic step(input logic e, input logic w, input logic a, input logic [31:0] d,
                      input logic [15:0] xd, input logic xb, input logic xo,
                      input logic [31:0] xr, input bit cr, input string nm);
    exp_t x;
    x.name = nm; x.dout = xd; x.busy = xb; x.ovf = xo; x.rdata = xr; x.chk_rdata = cr;
    sb.push_back(x);
    applyStimulus(e, w, a, d);
    checkOutput();
  endtask

  task automatic dec_value(input logic [15:0] v, input string nm);
    m_ovf = (v > 16'd9999);
    step(1'b1, 1'b1, 1'b0, {16'hDEAD, v}, m_dout, 1'b1, m_ovf, 32'h0, 1'b0, nm);
  endtask

  task automatic idle_busy(input int n, input string nm);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 32'h0, m_dout, 1'b1, m_ovf, 32'h0, 1'b0, nm);
  endtask

  task automatic idle_quiet(input int n, input string nm);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 1'b0, 32'h5A5A5A5A, m_dout, 1'b0, m_ovf, m_rdata, 1'b1, nm);
  endtask

  task automatic conv_done(input logic [15:0] v, input string nm);
    m_dout = to_bcd(v);
    step(1'b0, 1'b0, 1'b0, 32'h0, m_dout, 1'b0, m_ovf, 32'h0, 1'b0, nm);
  endtask

  task automatic full_conv(input logic [15:0] v, input string nm);
    dec_value(v, {nm, "_load"});
    idle_busy(13, {nm, "_busy"});
    conv_done(v, {nm, "_done"});
  endtask

  vec_t vecs[9];

  initial begin
    // Hex-mode bus vectors; rdata column is the value held after each edge.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'hABCD1234, 16'h1234, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 16'h1234, 32'h00001234};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000FFFF, 16'hFFFF, 32'h00001234};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h00005555, 16'hFFFF, 32'h00001234};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h11111111, 16'hFFFF, 32'h0000FFFF};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 16'hFFFF, 32'h00000000};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 16'hFFFF, 32'h00000000};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h00000001, 16'hFFFF, 32'h00000000};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 16'hFFFF, 32'h00000001};

    rst = 1'b1; ena = 1'b0; we = 1'b0; addr = 1'b0; wdata = '0;
    #12;
    chk("reset_data_out", {16'h0, data_out}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_ovf", {31'h0, ovf}, 32'h0);
    chk("reset_scan_ena", {31'h0, scan_ena}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("scan_edge%0d", k), {31'h0, scan_ena}, {31'h0, ((k % DIV) == DIV - 1)});
    end

    m_dout = 16'h0; m_ovf = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].e, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].dout, 1'b0, 1'b0,
           vecs[i].rdata, 1'b1, $sformatf("vec%0d", i));
    end
    m_dout = 16'hFFFF;
    m_rdata = 32'h1;

    // Decimal mode is now on; straight conversions including saturation.
    full_conv(16'h04D2, "dec1234");
    full_conv(16'hFFFF, "dec_sat");
    full_conv(16'h0000, "dec_zero");
    for (int r = 0; r < 3; r++) full_conv(16'($urandom_range(0, 12000)), $sformatf("dec_rand%0d", r));

    // Latest write wins: 500 restarted by 42 at CONV cycle 5.
    dec_value(16'd500, "restart_first");
    idle_busy(4, "restart_pre");
    dec_value(16'd42, "restart_second");
    idle_busy(13, "restart_busy");
    conv_done(16'd42, "restart_done");
    chk("restart_value", {16'h0, data_out}, 32'h00000042);

    // CTRL rewrite of 1 mid-conversion leaves the step count untouched.
    dec_value(16'd321, "keep_load");
    idle_busy(2, "keep_pre");
    step(1'b1, 1'b1, 1'b1, 32'h00000001, m_dout, 1'b1, m_ovf, 32'h0, 1'b0, "keep_ctrl");
    idle_busy(10, "keep_busy");
    conv_done(16'd321, "keep_done");

    // Switching to hex mid-conversion aborts and shows the raw value.
    dec_value(16'hFFFF, "abort_load");
    idle_busy(3, "abort_pre");
    m_dout = 16'hFFFF; m_ovf = 1'b0;
    step(1'b1, 1'b1, 1'b1, 32'h00000000, m_dout, 1'b0, m_ovf, 32'h0, 1'b0, "abort_ctrl");
    idle_quiet(15, "abort_after");
    step(1'b1, 1'b1, 1'b1, 32'h00000001, m_dout, 1'b0, m_ovf, m_rdata, 1'b1, "reenable");

    // Asynchronous reset in the middle of a conversion.
    dec_value(16'd8888, "rst_load");
    idle_busy(5, "rst_pre");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_data_out", {16'h0, data_out}, 32'h0);
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    chk("rstmid_ovf", {31'h0, ovf}, 32'h0);
    chk("rstmid_rdata", rdata, 32'h0);
    chk("rstmid_scan_ena", {31'h0, scan_ena}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_dout = 16'h0; m_ovf = 1'b0; m_rdata = 32'h0;
    idle_quiet(20, "rst_after");
    step(1'b1, 1'b1, 1'b0, 32'h000000AB, 16'h00AB, 1'b0, 1'b0, 32'h0, 1'b1, "post_rst_hex");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter: DIV, default 50000, scan-tick period in clk cycles (legal 2..2^20).
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ena  input  1  peripheral select from bus decoder.
REQ-005 FEPU_BEPU_w  input  1  bus write strobe, effective only with ena=1.
REQ-006 addr  input  1  register select: 0 = VALUE, 1 = CTRL.
REQ-007 wdata  input  32  bus write data.
REQ-008 rdata  output  32  registered read data.
REQ-009 data_out  output  16  four 4-bit digit codes for the downstream 4-digit 7-segment display; [15:12] is the leftmost digit.
REQ-010 scan_ena  output  1  one-cycle refresh pulse for the downstream digit scanner.
REQ-011 busy  output  1  decimal conversion in progress.
REQ-012 ovf  output  1  last decimal conversion saturated.

Function
REQ-013 Write: ena=1 and FEPU_BEPU_w=1 at a rising edge; all other cycles do not write.
REQ-014 VALUE write: stores wdata[15:0] in value_reg; wdata[31:16] is ignored.
REQ-015 CTRL write: stores wdata[0] as dec_mode (0 = hex, 1 = decimal); other bits are ignored.
REQ-016 Read, ena=1 and FEPU_BEPU_w=0: rdata at the next edge = {16'h0, value_reg} for addr 0, {31'h0, dec_mode} for addr 1; otherwise rdata holds its value.
REQ-017 Hex mode, VALUE write at edge N: data_out = wdata[15:0] after edge N; busy stays 0; ovf := 0.
REQ-018 Decimal mode FSM states are IDLE and CONV.
REQ-019 Decimal mode, VALUE write at edge N:
- Load the source: wdata[15:0] if <= 9999, else 9999 with ovf := 1 (otherwise ovf := 0).
- Clear the BCD accumulator and the shift counter; state := CONV; busy = 1 after edge N.
REQ-020 CONV, edges N+1..N+14: one double-dabble step per edge over the 14 LSBs of the source, MSB first:
- add 3 to each BCD nibble >= 5;
- then shift left 1, taking in the next source bit.
REQ-021 At edge N+14 (the 14th step): data_out := the BCD result (4 nibbles); state := IDLE; busy := 0; latency 14 cycles.
REQ-022 data_out holds its previous value throughout CONV; partial results are never visible.
REQ-023 VALUE write during CONV restarts the conversion with the new value (latest write wins); the restart edge counts as edge N.
REQ-024 CTRL write setting dec_mode=0 during CONV aborts: state := IDLE, busy := 0, data_out := value_reg at that edge, ovf := 0.
REQ-025 CTRL write setting dec_mode=1 while IDLE does not reconvert; data_out changes only on the next VALUE write.
REQ-026 CTRL write leaving dec_mode=1 during CONV does not disturb the conversion.
REQ-027 Scan divider:
- A free-running counter 0..DIV-1 wraps to 0.
- scan_ena = 1 for exactly the one cycle in which the counter equals DIV-1, independent of bus activity.

Reset
REQ-028 While rst=1 (asynchronous):
- data_out = 16'h0000, rdata = 0, value_reg = 0, dec_mode = 0.
- busy = 0, ovf = 0, scan_ena = 0, divider counter = 0, state = IDLE.
REQ-029 rst asserted mid-CONV abandons the conversion; after release the block is in the REQ-028 state and no late data_out update occurs.

Verification
REQ-030 Hex write, addr 0, wdata=32'hABCD1234 -> data_out=16'h1234 after the same edge, busy=0, rdata on read addr 0 = 32'h00001234.
REQ-031 CTRL=1, then VALUE=1234 (16'h04D2) at edge N:
- busy=1 during edges N+1..N+14;
- data_out=16'h1234 after edge N+14, ovf=0.
REQ-032 Decimal, VALUE=16'hFFFF -> data_out=16'h9999 after 14 cycles, ovf=1; then VALUE=0 -> data_out=16'h0000, ovf=0.
REQ-033 Decimal, VALUE=500, then VALUE=42 at cycle 5 of CONV -> data_out never shows 0500; data_out=16'h0042 14 edges after the second write.
REQ-034 DIV=4 -> scan_ena pulses on cycles 4, 8, 12 after reset release; rst asserted mid-CONV -> data_out=0, busy=0 immediately, no update after release.
